spi_arbiter: RTL
================

# spi_arbiter

Shares the single SPI byte engine and the flash chip select between two requesters: port 0, the CPU I/O register path, and port 1, the flash streaming loader. It grants whole chip-select transactions, round-robin, and holds SS high for a guaranteed gap between owners. It screens the first byte of every transaction against the forbidden dual/quad command set. It sits between the bus-facing register logic and the SPI shifter, and it drives SPI_SS directly.

## Interface
- GAP_CYCLES, 4: minimum CLK1 cycles SS stays high between transactions (flash tSHSL); legal range 1..15.
- CLK1 input 1: system clock; all logic on its rising edge.
- RESET input 1: asynchronous, active-high reset.
- cs_req0 / cs_req1, input, 1 each: requester wants ownership; held high for the whole transaction.
- vld0 / vld1, input, 1 each: byte request from the owner; level, held until done.
- dir0 / dir1, input, 1 each: 1 = write wdata, 0 = read (shifts out 0x00).
- wdata0 / wdata1, input, 8 each: byte to send.
- gnt0 / gnt1, output, 1 each: requester owns the SPI bus.
- done0 / done1, output, 1 each: one-cycle pulse when the byte completes or is rejected.
- err0 / err1, output, 1 each: one-cycle pulse, coincident with done, when a forbidden command is rejected.
- rdata, output, 8: byte captured by the engine; valid in the done cycle and held until the next done.
- eng_start, output, 1: one-cycle start pulse to the byte engine.
- eng_dir, output, 1: direction of the byte in flight.
- eng_wdata, output, 8: byte in flight.
- eng_busy, input, 1: engine is shifting.
- eng_done, input, 1: one-cycle pulse from the engine when the byte finishes.
- eng_rdata, input, 8: received byte, valid with eng_done.
- SPI_SS, output, 1: flash chip select, active low.

## Operation
- States: IDLE, GAP, OWNED, XFER, FAULT.
- IDLE:
  - Both cs_req low: stay in IDLE.
  - Exactly one cs_req high: grant that port and enter OWNED.
  - Both high: grant the port that was not `last`. `last` resets to 1, so port 0 wins the first tie.
- OWNED:
  - SPI_SS = 0; gnt of the owner = 1; `first` flag is set on entry.
  - Owner vld high and eng_busy low: check the byte first.
  - The byte is forbidden when `first` = 1, dir = 1 and wdata is 0x3B, 0x6B, 0xEB, 0xBB, 0x77, 0x32, 0x92 or 0x94. Then pulse done and err, drop SS, and enter FAULT.
  - Any other byte: latch eng_dir/eng_wdata, pulse eng_start, clear `first`, and enter XFER.
  - Owner cs_req low and no byte pending: release. Record `last` = owner, drop gnt, drive SS high, and enter GAP.
- XFER:
  - On eng_done: rdata <= eng_rdata, pulse the owner's done, and return to OWNED.
  - cs_req dropping mid-byte does not abort the byte. Release happens in OWNED after done.
- FAULT:
  - SPI_SS = 1, gnt stays asserted, and vld is ignored (no done).
  - When the owner's cs_req goes low: record `last` and enter GAP.
- GAP:
  - SS = 1 and no grants.
  - Count GAP_CYCLES cycles, then enter IDLE.
  - Requests arriving during GAP wait; arbitration happens in IDLE.
- Only the owner's done/err ever pulses. The non-owner's vld is ignored.
- `first` applies to write bytes only. A read as the first byte clears `first`, so a later write in the same transaction is not screened.

## Timing
- Reset values: SPI_SS = 1, gnt = 0, done = 0, err = 0, eng_start = 0, eng_dir = 0, eng_wdata = 0x00, rdata = 0x00; state = IDLE, `last` = 1.
- RESET asserted mid-transfer: SS rises asynchronously and the engine's eng_done is ignored after reset.
- Grant latency: cs_req high at edge N gives gnt/SS low after edge N+1 (one-cycle IDLE->OWNED).
- Start latency: vld sampled high in OWNED gives eng_start in the next cycle. eng_start never pulses while eng_busy = 1.
- The done pulse registers on the edge after eng_done. vld may then be held for the next byte: there is no dead cycle beyond OWNED's one check cycle.
- Release-to-regrant: at least GAP_CYCLES + 2 cycles of SS high (release cycle + GAP + IDLE).
- eng_done arriving outside XFER is ignored.

## Test plan
- Single owner:
  - Stimulus: cs_req0=1, write 0x03, 0x00, 0x10, 0x00, then one read; the engine returns 0xA5; release.
  - Required: four done0 pulses with no err, then a final done0 with rdata = 0xA5; SS low throughout; afterwards SS high for at least GAP_CYCLES+2 cycles.
- Tie arbitration after reset:
  - Stimulus: cs_req0 and cs_req1 rise together.
  - Required: gnt0 first. After port 0 releases and port 1's transaction completes, a fresh tie grants port 0 again, and the tie after that grants port 1 (alternation).
- Forbidden first byte:
  - Stimulus: port 1 is granted and writes 0xEB.
  - Required: done1 and err1 pulse together; eng_start never pulses; SS high; port 0 is not granted until port 1 drops cs_req and the gap elapses.
- Allowed non-first byte:
  - Stimulus: 0x3B written as the second byte.
  - Required: eng_start pulses with eng_wdata = 0x3B and no err.
- Release mid-byte:
  - Stimulus: cs_req0 drops while the engine is busy.
  - Required: SS stays low until done0, then rises the next cycle.
- Reset mid-XFER:
  - Stimulus: RESET pulses while the engine is busy.
  - Required: SS = 1 immediately, gnt = 0, and a late eng_done produces no done.

Source files
------------

// File: rtl/spi_arbiter.sv
// spi_arbiter
//   Shares one SPI byte engine and the flash chip select between two
//   requesters (port 0: CPU register path, port 1: flash streaming loader).
//   Grants whole chip-select transactions round-robin. Keeps SS high for a
//   guaranteed gap between owners. Rejects forbidden dual/quad commands when
//   they are written as the first byte of a transaction.
//
// Ports
//   CLK1, RESET                    clock, async active-high reset
//   cs_req*/vld*/dir*/wdata*       requester side (per port)
//   gnt*/done*/err*, rdata         requester status, captured read byte
//   eng_start/eng_dir/eng_wdata    byte engine command
//   eng_busy/eng_done/eng_rdata    byte engine status
//   SPI_SS                         flash chip select, active low
//
// state | meaning
// IDLE  | no owner, SS high, arbitrate pending requests
// OWNED | owner holds SS low, checks/launches the next byte or releases
// XFER  | byte in flight on the engine, waiting for eng_done
// FAULT | forbidden command rejected, SS high, wait for owner to drop cs_req
// GAP   | SS high for the inter-owner gap, down-counter to zero

module spi_arbiter #(
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic       CLK1,
    input  logic       RESET,
    input  logic       cs_req0,
    input  logic       cs_req1,
    input  logic       vld0,
    input  logic       vld1,
    input  logic       dir0,
    input  logic       dir1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic       err0,
    output logic       err1,
    output logic [7:0] rdata,
    output logic       eng_start,
    output logic       eng_dir,
    output logic [7:0] eng_wdata,
    input  logic       eng_busy,
    input  logic       eng_done,
    input  logic [7:0] eng_rdata,
    output logic       SPI_SS
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GAP   = 3'd1,
        OWNED = 3'd2,
        XFER  = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic        first_q, first_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic [1:0]  done_q, done_d;
    logic [1:0]  err_q, err_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        eng_start_q, eng_start_d;
    logic        eng_dir_q, eng_dir_d;
    logic [7:0]  eng_wdata_q, eng_wdata_d;

    logic        own_req;
    logic        own_vld;
    logic        own_dir;
    logic [7:0]  own_wdata;
    logic        owned;
    logic        has_gnt;

    function automatic logic is_forbidden(input logic [7:0] cmd);
        logic hit;
        hit = 1'b0;
        case (cmd)
            8'h3B, 8'h6B, 8'hEB, 8'hBB,
            8'h77, 8'h32, 8'h92, 8'h94: hit = 1'b1;
            default:                     hit = 1'b0;
        endcase
        return hit;
    endfunction

    always_comb begin
        own_req   = owner_q ? cs_req1 : cs_req0;
        own_vld   = owner_q ? vld1    : vld0;
        own_dir   = owner_q ? dir1    : dir0;
        own_wdata = owner_q ? wdata1  : wdata0;
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        first_d     = first_q;
        gap_cnt_d   = gap_cnt_q;
        done_d      = 2'b00;
        err_d       = 2'b00;
        rdata_d     = rdata_q;
        eng_start_d = 1'b0;
        eng_dir_d   = eng_dir_q;
        eng_wdata_d = eng_wdata_q;

        case (state_q)
            IDLE: begin
                if (cs_req0 && cs_req1) begin
                    owner_d = ~last_q;
                    first_d = 1'b1;
                    state_d = OWNED;
                end else if (cs_req0) begin
                    owner_d = 1'b0;
                    first_d = 1'b1;
                    state_d = OWNED;
                end else if (cs_req1) begin
                    owner_d = 1'b1;
                    first_d = 1'b1;
                    state_d = OWNED;
                end
            end

            OWNED: begin
                // A pending byte takes priority over release, so a requester
                // that drops cs_req with vld still high gets its byte first.
                if (own_vld && !eng_busy) begin
                    if (first_q && own_dir && is_forbidden(own_wdata)) begin
                        done_d[owner_q] = 1'b1;
                        err_d[owner_q]  = 1'b1;
                        state_d         = FAULT;
                    end else begin
                        eng_start_d = 1'b1;
                        eng_dir_d   = own_dir;
                        eng_wdata_d = own_dir ? own_wdata : 8'h00;
                        first_d     = 1'b0;
                        state_d     = XFER;
                    end
                end else if (!own_req) begin
                    last_d    = owner_q;
                    gap_cnt_d = 4'(GAP_CYCLES);
                    state_d   = GAP;
                end
            end

            XFER: begin
                if (eng_done) begin
                    rdata_d         = eng_rdata;
                    done_d[owner_q] = 1'b1;
                    state_d         = OWNED;
                end
            end

            FAULT: begin
                if (!own_req) begin
                    last_d    = owner_q;
                    gap_cnt_d = 4'(GAP_CYCLES);
                    state_d   = GAP;
                end
            end

            GAP: begin
                // Loaded with GAP_CYCLES and left at zero, so GAP lasts
                // GAP_CYCLES+1 cycles; together with IDLE that gives at least
                // GAP_CYCLES+2 cycles of SS high between owners.
                if (gap_cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK1 or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            first_q     <= 1'b0;
            gap_cnt_q   <= 4'd0;
            done_q      <= 2'b00;
            err_q       <= 2'b00;
            rdata_q     <= 8'h00;
            eng_start_q <= 1'b0;
            eng_dir_q   <= 1'b0;
            eng_wdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            first_q     <= first_d;
            gap_cnt_q   <= gap_cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            eng_start_q <= eng_start_d;
            eng_dir_q   <= eng_dir_d;
            eng_wdata_q <= eng_wdata_d;
        end
    end

    // SS and grants decode straight from the state flops, so reset raises SS
    // asynchronously and the chip select never sees a glitch from inputs.
    always_comb begin
        owned   = (state_q == OWNED) || (state_q == XFER);
        has_gnt = owned || (state_q == FAULT);
        gnt0    = has_gnt && !owner_q;
        gnt1    = has_gnt && owner_q;
        SPI_SS  = !owned;
    end

    assign done0     = done_q[0];
    assign done1     = done_q[1];
    assign err0      = err_q[0];
    assign err1      = err_q[1];
    assign rdata     = rdata_q;
    assign eng_start = eng_start_q;
    assign eng_dir   = eng_dir_q;
    assign eng_wdata = eng_wdata_q;

endmodule
